hyperbus_w_serializer: RTL and testbench

- Sits directly upstream of the HyperBus PHY TX channel, between the AXI-side front end and the PHY.
- Accepts one write command per transfer and consumes wide AXI W beats.
- Emits one 16-bit data word with a 2-bit byte strobe per PHY handshake, starting at the command's word offset inside the first beat.
- Checks that W-beat framing (w_last) matches the commanded word count, and reports completion with an error flag.

---
 rtl/hyperbus_w_serializer.sv | 188 ++++++++++++++++++
 tb/tb_hyperbus_w_serializer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_w_serializer.sv
// HyperBus write-data serializer: splits wide AXI W beats into 16-bit PHY words,
// starting at the command's word offset, and checks W framing against the word count.
module hyperbus_w_serializer #(
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned BurstWidth   = 16,
   localparam int unsigned WordsPerBeat = AxiDataWidth / 16,
   localparam int unsigned OffWidth     = $clog2(WordsPerBeat)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [OffWidth-1:0]       cmd_word_off_i,
   input  logic [BurstWidth-1:0]     cmd_num_words_i,
   input  logic                      w_valid_i,
   output logic                      w_ready_o,
   input  logic [AxiDataWidth-1:0]   w_data_i,
   input  logic [AxiDataWidth/8-1:0] w_strb_i,
   input  logic                      w_last_i,
   output logic                      tx_valid_o,
   input  logic                      tx_ready_i,
   output logic [15:0]               tx_data_o,
   output logic [1:0]                tx_strb_o,
   output logic                      done_o,
   output logic                      done_err_o
);

   typedef enum logic [2:0] {StIdle, StFetch, StEmit, StPad, StDrain} state_e;

   state_e                    state_q, state_d;
   logic [AxiDataWidth-1:0]   buf_data_q, buf_data_d;
   logic [AxiDataWidth/8-1:0] buf_strb_q, buf_strb_d;
   logic                      buf_last_q, buf_last_d;
   logic                      buf_valid_q, buf_valid_d;
   logic [OffWidth-1:0]       idx_q, idx_d;
   logic [BurstWidth-1:0]     remaining_q, remaining_d;
   logic                      err_q, err_d;
   logic                      done_q, done_d;
   logic                      done_err_q, done_err_d;

   logic cmd_hs, w_hs, tx_hs, last_word, beat_end;

   assign cmd_hs    = cmd_valid_i & cmd_ready_o;
   assign w_hs      = w_valid_i & w_ready_o;
   assign tx_hs     = tx_valid_o & tx_ready_i;
   assign last_word = (remaining_q == BurstWidth'(1));
   assign beat_end  = (idx_q == OffWidth'(WordsPerBeat - 1));

   assign done_o     = done_q;
   assign done_err_o = done_err_q;

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         buf_data_q  <= '0;
         buf_strb_q  <= '0;
         buf_last_q  <= 1'b0;
         buf_valid_q <= 1'b0;
         idx_q       <= '0;
         remaining_q <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         done_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_data_q  <= buf_data_d;
         buf_strb_q  <= buf_strb_d;
         buf_last_q  <= buf_last_d;
         buf_valid_q <= buf_valid_d;
         idx_q       <= idx_d;
         remaining_q <= remaining_d;
         err_q       <= err_d;
         done_q      <= done_d;
         done_err_q  <= done_err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      buf_data_d  = buf_data_q;
      buf_strb_d  = buf_strb_q;
      buf_last_d  = buf_last_q;
      buf_valid_d = buf_valid_q;
      idx_d       = idx_q;
      remaining_d = remaining_q;
      err_d       = err_q;
      done_d      = 1'b0;
      done_err_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_hs) begin
               idx_d       = cmd_word_off_i;
               remaining_d = cmd_num_words_i;
               err_d       = 1'b0;
               state_d     = StFetch;
               if (cmd_num_words_i == '0) begin
                  err_d   = 1'b1;
                  state_d = StDrain;
               end
            end
         end
         StFetch: begin
            if (w_hs) begin
               buf_data_d  = w_data_i;
               buf_strb_d  = w_strb_i;
               buf_last_d  = w_last_i;
               buf_valid_d = 1'b1;
               state_d     = StEmit;
            end
         end
         StEmit: begin
            if (tx_hs) begin
               remaining_d = remaining_q - BurstWidth'(1);
               idx_d       = idx_q + OffWidth'(1);
               if (last_word) begin
                  buf_valid_d = 1'b0;
                  if (buf_last_q) begin
                     done_d     = 1'b1;
                     done_err_d = err_q;
                     state_d    = StIdle;
                  end else begin
                     err_d   = 1'b1;
                     state_d = StDrain;
                  end
               end else if (beat_end) begin
                  if (buf_last_q) begin
                     // W ended early: pad out the burst with masked words
                     err_d       = 1'b1;
                     buf_valid_d = 1'b0;
                     state_d     = StPad;
                  end else if (w_hs) begin
                     // Refill in the same cycle to avoid a bubble at the beat boundary
                     buf_data_d = w_data_i;
                     buf_strb_d = w_strb_i;
                     buf_last_d = w_last_i;
                  end else begin
                     buf_valid_d = 1'b0;
                     state_d     = StFetch;
                  end
               end
            end
         end
         StPad: begin
            if (tx_hs) begin
               remaining_d = remaining_q - BurstWidth'(1);
               if (last_word) begin
                  done_d     = 1'b1;
                  done_err_d = 1'b1;
                  state_d    = StIdle;
               end
            end
         end
         StDrain: begin
            if (w_hs && w_last_i) begin
               done_d     = 1'b1;
               done_err_d = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake and data outputs
   always_comb begin
      cmd_ready_o = 1'b0;
      w_ready_o   = 1'b0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      tx_strb_o   = '0;
      unique case (state_q)
         StIdle:  cmd_ready_o = 1'b1;
         StFetch: w_ready_o = 1'b1;
         StEmit: begin
            tx_valid_o = buf_valid_q;
            tx_data_o  = buf_data_q[{idx_q, 4'b0000} +: 16];
            tx_strb_o  = buf_strb_q[{idx_q, 1'b0} +: 2];
            w_ready_o  = buf_valid_q & tx_ready_i & ~last_word & beat_end & ~buf_last_q;
         end
         StPad:   tx_valid_o = 1'b1;
         StDrain: w_ready_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_hyperbus_w_serializer.sv
// Directed bench for hyperbus_w_serializer (AxiDataWidth = 64).
module tb_hyperbus_w_serializer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_word_off_i;
   logic [15:0] cmd_num_words_i;
   logic        w_valid_i;
   logic        w_ready_o;
   logic [63:0] w_data_i;
   logic [7:0]  w_strb_i;
   logic        w_last_i;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [15:0] tx_data_o;
   logic [1:0]  tx_strb_o;
   logic        done_o;
   logic        done_err_o;

   hyperbus_w_serializer #(
      .AxiDataWidth(64),
      .BurstWidth  (16)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cmd_valid_i    (cmd_valid_i),
      .cmd_ready_o    (cmd_ready_o),
      .cmd_word_off_i (cmd_word_off_i),
      .cmd_num_words_i(cmd_num_words_i),
      .w_valid_i      (w_valid_i),
      .w_ready_o      (w_ready_o),
      .w_data_i       (w_data_i),
      .w_strb_i       (w_strb_i),
      .w_last_i       (w_last_i),
      .tx_valid_o     (tx_valid_o),
      .tx_ready_i     (tx_ready_i),
      .tx_data_o      (tx_data_o),
      .tx_strb_o      (tx_strb_o),
      .done_o         (done_o),
      .done_err_o     (done_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor: record accepted tx words, W handshakes and done pulses mid-cycle
   logic [17:0] q_tx[$];
   int          q_cyc[$];
   int          w_hs     = 0;
   int          done_cnt = 0;
   logic        last_err = 1'b0;

   always @(negedge clk_i) begin
      if (tx_valid_o && tx_ready_i) begin
         q_tx.push_back({tx_data_o, tx_strb_o});
         q_cyc.push_back(cyc);
      end
      if (w_valid_i && w_ready_o) w_hs++;
      if (done_o) begin
         done_cnt++;
         last_err = done_err_o;
      end
   end

   // W source: presents beats wd[0..w_n-1] in order, advancing on each handshake
   logic [63:0] wd[4];
   logic [7:0]  ws[4];
   logic        wl[4];
   int          w_n     = 0;
   int          w_start = 0;

   initial begin
      int k;
      w_valid_i = 1'b0;
      w_data_i  = '0;
      w_strb_i  = '0;
      w_last_i  = 1'b0;
      forever begin
         @(posedge clk_i);
         #2;
         k = w_hs - w_start;
         if (k < w_n) begin
            w_valid_i = 1'b1;
            w_data_i  = wd[k];
            w_strb_i  = ws[k];
            w_last_i  = wl[k];
         end else begin
            w_valid_i = 1'b0;
            w_data_i  = '0;
            w_strb_i  = '0;
            w_last_i  = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_beat(input int i, input logic [63:0] d, input logic [7:0] s,
                           input logic l);
      wd[i] = d;
      ws[i] = s;
      wl[i] = l;
   endtask

   task automatic arm(input int n);
      w_start = w_hs;
      w_n     = n;
   endtask

   // Called at posedge+1; returns at posedge+1 after the command handshake
   task automatic start_cmd(input logic [1:0] off, input logic [15:0] n);
      bit hs = 1'b0;
      cmd_valid_i     = 1'b1;
      cmd_word_off_i  = off;
      cmd_num_words_i = n;
      for (int i = 0; i < 20 && !hs; i++) begin
         @(negedge clk_i);
         hs = cmd_ready_o;
         @(posedge clk_i);
         #1;
      end
      cmd_valid_i = 1'b0;
      chk("cmd_accept", 64'(hs), 64'd1);
   endtask

   task automatic wait_done(input int budget);
      int s = done_cnt;
      bit got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(posedge clk_i);
         got = (done_cnt != s);
      end
      #1;
      chk("done_seen", 64'(got), 64'd1);
   endtask

   task automatic check_words(input string tag, input int t0, input int n,
                              input logic [17:0] e[$]);
      chk({tag, "_count"}, 64'(q_tx.size() - t0), 64'(n));
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_w%0d", tag, i), 64'(q_tx[t0+i]), 64'(e[i]));
   endtask

   initial begin
      int t0;
      bit seen;
      rst_ni          = 1'b0;
      cmd_valid_i     = 1'b0;
      cmd_word_off_i  = '0;
      cmd_num_words_i = '0;
      tx_ready_i      = 1'b1;

      // Reset state
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_w_ready",   64'(w_ready_o),   64'd0);
      chk("rst_tx_valid",  64'(tx_valid_o),  64'd0);
      chk("rst_tx_data",   64'(tx_data_o),   64'd0);
      chk("rst_tx_strb",   64'(tx_strb_o),   64'd0);
      chk("rst_done",      64'(done_o),      64'd0);
      chk("rst_done_err",  64'(done_err_o),  64'd0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Two full beats, off 0: eight words back to back
      set_beat(0, 64'h4444_3333_2222_1111, 8'hFF, 1'b0);
      set_beat(1, 64'h8888_7777_6666_5555, 8'hFF, 1'b1);
      arm(2);
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd8);
      wait_done(40);
      check_words("t1", t0, 8, '{{16'h1111, 2'b11}, {16'h2222, 2'b11}, {16'h3333, 2'b11},
                                 {16'h4444, 2'b11}, {16'h5555, 2'b11}, {16'h6666, 2'b11},
                                 {16'h7777, 2'b11}, {16'h8888, 2'b11}});
      chk("t1_no_bubble", 64'(q_cyc[t0+7] - q_cyc[t0]), 64'd7);
      chk("t1_err", 64'(last_err), 64'd0);
      @(negedge clk_i);
      chk("t1_done_pulse", 64'(done_o), 64'd0);
      @(posedge clk_i);
      #1;

      // Offset 3, two words spanning a beat boundary
      set_beat(0, 64'h1111_2222_3333_4444, 8'hFF, 1'b0);
      set_beat(1, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
      arm(2);
      t0 = q_tx.size();
      start_cmd(2'd3, 16'd2);
      wait_done(40);
      check_words("t2", t0, 2, '{{16'h1111, 2'b11}, {16'hDDDD, 2'b11}});
      chk("t2_err", 64'(last_err), 64'd0);

      // Early w_last: four data words then two masked pad words
      set_beat(0, 64'h0004_0003_0002_0001, 8'hD7, 1'b1);
      arm(1);
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd6);
      wait_done(40);
      check_words("t3", t0, 6, '{{16'h0001, 2'b11}, {16'h0002, 2'b01}, {16'h0003, 2'b01},
                                 {16'h0004, 2'b11}, {16'h0000, 2'b00}, {16'h0000, 2'b00}});
      chk("t3_err", 64'(last_err), 64'd1);

      // Late w_last: two words then the remaining beats are drained
      set_beat(0, 64'h0000_0000_BBBB_AAAA, 8'hFF, 1'b0);
      set_beat(1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0);
      set_beat(2, 64'h0FED_CBA9_8765_4321, 8'hFF, 1'b1);
      arm(3);
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd2);
      wait_done(40);
      check_words("t4", t0, 2, '{{16'hAAAA, 2'b11}, {16'hBBBB, 2'b11}});
      chk("t4_w_beats", 64'(w_hs - w_start), 64'd3);
      chk("t4_err", 64'(last_err), 64'd1);

      // Backpressure: data held stable across a two-cycle stall
      tx_ready_i = 1'b0;
      set_beat(0, 64'hDEAD_BEEF_CAFE_F00D, 8'h5A, 1'b1);
      arm(1);
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd4);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         seen = tx_valid_o;
      end
      chk("t5_valid_seen", 64'(seen), 64'd1);
      @(posedge clk_i);
      #1 tx_ready_i = 1'b1;
      @(negedge clk_i);
      chk("t5_w0", 64'({tx_data_o, tx_strb_o}), 64'({16'hF00D, 2'b10}));
      @(posedge clk_i);
      #1 tx_ready_i = 1'b0;
      @(negedge clk_i);
      chk("t5_stall_a", 64'({tx_valid_o, tx_data_o, tx_strb_o}), 64'({1'b1, 16'hCAFE, 2'b10}));
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      chk("t5_stall_b", 64'({tx_valid_o, tx_data_o, tx_strb_o}), 64'({1'b1, 16'hCAFE, 2'b10}));
      @(posedge clk_i);
      #1 tx_ready_i = 1'b1;
      wait_done(40);
      check_words("t5", t0, 4, '{{16'hF00D, 2'b10}, {16'hCAFE, 2'b10}, {16'hBEEF, 2'b01},
                                 {16'hDEAD, 2'b01}});
      chk("t5_err", 64'(last_err), 64'd0);

      // Asynchronous reset mid-Emit with five words remaining
      tx_ready_i = 1'b0;
      set_beat(0, 64'h0004_0003_0002_0001, 8'hFF, 1'b0);
      set_beat(1, 64'h0008_0007_0006_0005, 8'hFF, 1'b1);
      arm(2);
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd8);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         seen = tx_valid_o;
      end
      @(posedge clk_i);
      #1 tx_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1 tx_ready_i = 1'b0;
      chk("t6_sent_before_rst", 64'(q_tx.size() - t0), 64'd3);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("t6_rst_w_ready",   64'(w_ready_o),   64'd0);
      chk("t6_rst_tx_valid",  64'(tx_valid_o),  64'd0);
      chk("t6_rst_tx_bus",    64'({tx_data_o, tx_strb_o}), 64'd0);
      chk("t6_rst_done",      64'({done_o, done_err_o}),   64'd0);
      @(posedge clk_i);
      #1;
      rst_ni     = 1'b1;
      tx_ready_i = 1'b1;
      set_beat(0, 64'h0000_0000_0000_ABCD, 8'h01, 1'b1);
      arm(1);
      @(negedge clk_i);
      chk("t6_cmd_ready_after", 64'(cmd_ready_o), 64'd1);
      @(posedge clk_i);
      #1;
      t0 = q_tx.size();
      start_cmd(2'd0, 16'd1);
      wait_done(40);
      check_words("t6", t0, 1, '{{16'hABCD, 2'b01}});
      chk("t6_err", 64'(last_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
